// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// prog_loader : assembles a host byte stream into 32-bit words, writes them to
//               instruction memory, then releases the processor.  Rev 1.0
// ============================================================================
module prog_loader #(
    parameter int BASE_ADDR = 0,
    parameter int AW        = 9
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic [AW-1:0] addr,
    output logic          wEn,
    output logic [31:0]   wDat,
    output logic          working,
    output logic          busy,
    output logic          err,
    output logic [8:0]    words_loaded
);

    localparam logic [7:0] CMD_LOAD = 8'hA5;
    localparam logic [7:0] CMD_HALT = 8'h5A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        RUN   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_idx;
    logic [7:0]  word_idx;
    logic [7:0]  word_count;
    logic [23:0] partial;
    logic        accept;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign last_word = (word_idx == (word_count - 8'd1));

    // Strobes decode straight from the state register, so wEn and working
    // can never overlap.
    assign in_ready = (state != WRITE);
    assign wEn      = (state == WRITE);
    assign working  = (state == RUN);
    assign busy     = (state == COUNT) || (state == DATA) || (state == WRITE);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (in_data == CMD_LOAD)) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (accept) begin
                    state_next = (in_data == 8'd0) ? RUN : DATA;
                end
            end
            DATA: begin
                if (accept && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = last_word ? RUN : DATA;
            end
            RUN: begin
                if (accept && (in_data == CMD_HALT)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx     <= 2'd0;
            word_idx     <= 8'd0;
            word_count   <= 8'd0;
            partial      <= 24'd0;
            addr         <= '0;
            wDat         <= 32'd0;
            err          <= 1'b0;
            words_loaded <= 9'd0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_data == CMD_LOAD) begin
                            words_loaded <= 9'd0;
                        end else if (in_data != CMD_HALT) begin
                            err <= 1'b1;
                        end
                    end
                end
                COUNT: begin
                    if (accept) begin
                        word_count <= in_data;
                        byte_idx   <= 2'd0;
                        word_idx   <= 8'd0;
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (byte_idx == 2'd3) begin
                            wDat <= {partial, in_data};
                            // Address deliberately wraps modulo 2^AW.
                            addr <= AW'(BASE_ADDR) + AW'(word_idx);
                        end else begin
                            partial  <= {partial[15:0], in_data};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    words_loaded <= words_loaded + 9'd1;
                    byte_idx     <= 2'd0;
                    if (!last_word) begin
                        word_idx <= word_idx + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_prog_loader : vector table plus directed load sequences for prog_loader.
// Rev 1.0
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        rdy0, wen0, work0, busy0, err0;
    logic [8:0]  addr0, wl0;
    logic [31:0] wdat0;
    logic        rdy1, wen1, work1, busy1, err1;
    logic [8:0]  addr1, wl1;
    logic [31:0] wdat1;

    int vectors = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    prog_loader #(.BASE_ADDR(0), .AW(9)) dut0 (
        .clock(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .addr(addr0), .wEn(wen0), .wDat(wdat0),
        .working(work0), .busy(busy0), .err(err0), .words_loaded(wl0)
    );

    prog_loader #(.BASE_ADDR(510), .AW(9)) dut1 (
        .clock(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .addr(addr1), .wEn(wen1), .wDat(wdat1),
        .working(work1), .busy(busy1), .err(err1), .words_loaded(wl1)
    );

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        wen;
        logic [8:0]  a0;
        logic [8:0]  a1;
        logic [31:0] wd;
        logic        work;
        logic        busy;
        logic        err;
        logic [8:0]  wl;
    } vec_t;

    vec_t tbl[$];
    logic [40:0] q0[$];
    logic [40:0] q1[$];

    // Write monitor: wEn is a full-cycle pulse, so each write is seen once.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wen0) q0.push_back({addr0, wdat0});
            if (wen1) q1.push_back({addr1, wdat1});
            if ((wen0 && work0) || (wen1 && work1)) begin
                miscompares++;
                $display("FAIL wen_while_working: got wEn=1 working=1, need never both");
            end
        end
    end

    function automatic void add(logic v, logic [7:0] d, logic rdy, logic wen,
                                logic [8:0] a0, logic [8:0] a1, logic [31:0] wd,
                                logic work, logic busy, logic err, logic [8:0] wl);
        vec_t r;
        r.v = v; r.d = d; r.rdy = rdy; r.wen = wen; r.a0 = a0; r.a1 = a1;
        r.wd = wd; r.work = work; r.busy = busy; r.err = err; r.wl = wl;
        tbl.push_back(r);
    endfunction

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, need %h", name, got, exp);
        end
    endtask

    task automatic send_byte(logic [7:0] b, int gap);
        int n;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!rdy0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            miscompares++;
            $display("FAIL ready_timeout: got in_ready=0 for %0d cycles, need 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_writes(string name);
        logic [40:0] e0, e1;
        check({name, "_count0"}, 64'(q0.size()), 64'd4);
        check({name, "_count1"}, 64'(q1.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            e0 = {9'(i), 8'h10, 8'(i), 8'h00, 8'(8'h1c + i)};
            e1 = {9'((510 + i) % 512), 8'h10, 8'(i), 8'h00, 8'(8'h1c + i)};
            check({name, "_write0"}, (i < q0.size()) ? 64'(q0[i]) : 64'hx, 64'(e0));
            check({name, "_write1"}, (i < q1.size()) ? 64'(q1[i]) : 64'hx, 64'(e1));
        end
    endtask

    // Full load of words 1000001c..1003001f with up to max_gap idle cycles between bytes.
    task automatic do_load(string name, int max_gap);
        logic [7:0] b;
        q0.delete();
        q1.delete();
        send_byte(8'hA5, $urandom_range(max_gap));
        send_byte(8'h04, $urandom_range(max_gap));
        for (int j = 0; j < 16; j++) begin
            case (j % 4)
                0: b = 8'h10;
                1: b = 8'(j / 4);
                2: b = 8'h00;
                default: b = 8'(8'h1c + j / 4);
            endcase
            send_byte(b, $urandom_range(max_gap));
            check({name, "_wen_after_byte"}, {63'd0, wen0}, {63'd0, ((j % 4) == 3)});
        end
        @(posedge clk);
        #1;
        check({name, "_run"}, {52'd0, work0, wen0, wl0, work1}, {52'd0, 1'b1, 1'b0, 9'd4, 1'b1});
        check_writes(name);
    endtask

    initial begin
        // Table: one record per clock; expectations are the outputs after that edge.
        //  v   data   rdy wen a0 a1    wDat          work busy err wl
        add(1, 8'hA5, 1, 0, 0, 0,   32'h0,        0, 1, 0, 0);
        add(1, 8'h04, 1, 0, 0, 0,   32'h0,        0, 1, 0, 0);
        add(1, 8'h10, 1, 0, 0, 0,   32'h0,        0, 1, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0,   32'h0,        0, 1, 0, 0);
        add(1, 8'h00, 1, 0, 0, 0,   32'h0,        0, 1, 0, 0);
        add(1, 8'h1c, 0, 1, 0, 510, 32'h1000001c, 0, 1, 0, 0);
        add(1, 8'h10, 1, 0, 0, 510, 32'h1000001c, 0, 1, 0, 1);
        add(1, 8'h10, 1, 0, 0, 510, 32'h1000001c, 0, 1, 0, 1);
        add(1, 8'h01, 1, 0, 0, 510, 32'h1000001c, 0, 1, 0, 1);
        add(1, 8'h00, 1, 0, 0, 510, 32'h1000001c, 0, 1, 0, 1);
        add(1, 8'h1d, 0, 1, 1, 511, 32'h1001001d, 0, 1, 0, 1);
        add(1, 8'h10, 1, 0, 1, 511, 32'h1001001d, 0, 1, 0, 2);
        add(1, 8'h10, 1, 0, 1, 511, 32'h1001001d, 0, 1, 0, 2);
        add(1, 8'h02, 1, 0, 1, 511, 32'h1001001d, 0, 1, 0, 2);
        add(1, 8'h00, 1, 0, 1, 511, 32'h1001001d, 0, 1, 0, 2);
        add(1, 8'h1e, 0, 1, 2, 0,   32'h1002001e, 0, 1, 0, 2);
        add(1, 8'h10, 1, 0, 2, 0,   32'h1002001e, 0, 1, 0, 3);
        add(1, 8'h10, 1, 0, 2, 0,   32'h1002001e, 0, 1, 0, 3);
        add(1, 8'h03, 1, 0, 2, 0,   32'h1002001e, 0, 1, 0, 3);
        add(1, 8'h00, 1, 0, 2, 0,   32'h1002001e, 0, 1, 0, 3);
        add(1, 8'h1f, 0, 1, 3, 1,   32'h1003001f, 0, 1, 0, 3);
        add(0, 8'h00, 1, 0, 3, 1,   32'h1003001f, 1, 0, 0, 4);
        add(1, 8'h33, 1, 0, 3, 1,   32'h1003001f, 1, 0, 0, 4);
        add(1, 8'h5A, 1, 0, 3, 1,   32'h1003001f, 0, 0, 0, 4);
        add(1, 8'h33, 1, 0, 3, 1,   32'h1003001f, 0, 0, 1, 4);
        add(0, 8'h00, 1, 0, 3, 1,   32'h1003001f, 0, 0, 0, 4);
        add(1, 8'hA5, 1, 0, 3, 1,   32'h1003001f, 0, 1, 0, 0);
        add(1, 8'h00, 1, 0, 3, 1,   32'h1003001f, 1, 0, 0, 0);
        add(1, 8'h5A, 1, 0, 3, 1,   32'h1003001f, 0, 0, 0, 0);
        add(1, 8'hA5, 1, 0, 3, 1,   32'h1003001f, 0, 1, 0, 0);
        add(1, 8'h01, 1, 0, 3, 1,   32'h1003001f, 0, 1, 0, 0);
        add(1, 8'hA5, 1, 0, 3, 1,   32'h1003001f, 0, 1, 0, 0);
        add(1, 8'h5A, 1, 0, 3, 1,   32'h1003001f, 0, 1, 0, 0);
        add(1, 8'hA5, 1, 0, 3, 1,   32'h1003001f, 0, 1, 0, 0);
        add(1, 8'h5A, 0, 1, 0, 510, 32'ha55aa55a, 0, 1, 0, 0);
        add(0, 8'h00, 1, 0, 0, 510, 32'ha55aa55a, 1, 0, 0, 1);
        add(1, 8'h5A, 1, 0, 0, 510, 32'ha55aa55a, 0, 0, 0, 1);

        // Reset state
        #25;
        check("reset_state", {rdy0, wen0, addr0, addr1, wdat0, work0, busy0, err0, wl0},
              {1'b1, 1'b0, 9'd0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 9'd0});
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i),
                  {rdy0, wen0, addr0, addr1, wdat0, work0, busy0, err0, wl0},
                  {tbl[i].rdy, tbl[i].wen, tbl[i].a0, tbl[i].a1, tbl[i].wd,
                   tbl[i].work, tbl[i].busy, tbl[i].err, tbl[i].wl});
        end
        in_valid = 1'b0;

        // Same load with random idle gaps between bytes
        do_load("gaps", 5);

        // Halt, then reset after word 0 and two bytes of word 1
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h1c, 0);
        send_byte(8'h10, 0);
        send_byte(8'h01, 0);
        check("pre_reset_busy", {63'd0, busy0}, {63'd0, 1'b1});
        #2;
        rst_n = 1'b0;
        #1;
        check("midload_reset", {rdy0, wen0, addr0, addr1, wdat0, work0, busy0, err0, wl0},
              {1'b1, 1'b0, 9'd0, 9'd0, 32'd0, 1'b0, 1'b0, 1'b0, 9'd0});
        @(negedge clk);
        rst_n = 1'b1;

        do_load("reload", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Hardware initiator for the processor's instruction-memory load port (addr/wEn/wDat/working).
- Receives a byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive instruction-memory addresses while holding the processor stopped (working=0).
- When loading completes, it raises working to start execution. A halt command stops the processor again.
- Sits between a host byte source (UART/debug link) and the processor top.

Parameters:
- BASE_ADDR, 0, first instruction-memory address written by a load (9-bit).
- AW, 9, instruction-memory address width.

Ports:
- clock  input  1  system clock, 50 MHz; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte this cycle.
- addr  output  AW  instruction-memory write address (to processor addr).
- wEn  output  1  instruction-memory write enable, one-cycle pulse per word.
- wDat  output  32  instruction word (to processor wDat).
- working  output  1  processor run enable.
- busy  output  1  a load is in progress (states COUNT, DATA, WRITE).
- err  output  1  one-cycle pulse on an unrecognised command byte in IDLE.
- words_loaded  output  9  number of words written by the most recent load.

Behaviour:
- Byte transfer: a byte is accepted on a rising edge where in_valid=1 and in_ready=1. in_ready is combinational from state: 1 in IDLE, COUNT, DATA and RUN; 0 in WRITE.
- Reset (async, rst_n=0): state=IDLE; addr=0, wEn=0, wDat=0, working=0, busy=0, err=0, words_loaded=0. Any partial word or count is discarded. Reset mid-load leaves memory holding only the words already written.
- Commands in IDLE:
  - 0xA5 (LOAD) -> COUNT; clear words_loaded.
  - 0x5A (HALT) -> no effect.
  - Any other byte -> err=1 for one cycle; stay in IDLE.
- COUNT: the accepted byte N is the word count.
  - N=0 -> RUN directly; working=1 the cycle after acceptance.
  - N=1..255 -> DATA with byte index 0 and word index 0.
- DATA: bytes are big-endian, first byte is wDat[31:24]. No command decoding in DATA; 0xA5 and 0x5A are ordinary data. When the 4th byte is accepted at edge t, the following are registered and hold for exactly the cycle after t:
  - wDat = assembled word.
  - addr = (BASE_ADDR + word index) mod 2^AW, so the address wraps past 511.
  - wEn = 1.
  - State is WRITE for that cycle.
- WRITE (1 cycle):
  - wEn returns to 0 at the next edge; words_loaded increments.
  - If this was word N-1 -> RUN; otherwise -> DATA with byte index 0 and word index +1.
  - addr and wDat hold their last values after the write.
- RUN: working=1 from the first RUN cycle.
  - A 0x5A byte -> working=0 at the next edge and state returns to IDLE.
  - All other bytes are accepted and ignored. A new load requires HALT first.
- working is 0 in every state except RUN, so the processor never executes during a write. wEn is never 1 while working=1.
- Latency: from acceptance of the last data byte, wEn is high 1 cycle later and working rises 2 cycles later.
- Back-to-back bytes at full rate are legal; the stall is the single WRITE cycle per word.

Test Plan:
- Reset then load: send A5 04 10 00 00 1c 10 01 00 1d 10 02 00 1e 10 03 00 1f at full rate -> four wEn pulses with (addr, wDat) = (0, 1000001c), (1, 1001001d), (2, 1002001e), (3, 1003001f); in_ready low during each pulse; working=1 two cycles after the last byte; words_loaded=4. With the processor attached, r0..r3 = 28, 29, 30, 31.
- Gaps: same stream with in_valid deasserted for random 0-5 cycles between bytes -> identical writes and data. No wEn until the 4th byte of each word is accepted.
- Command handling: in IDLE send 0x33 -> err pulses for 1 cycle, no write. In RUN send 0x33 -> ignored, working stays 1. Send 0x5A -> working=0 next cycle, back in IDLE. Then A5 00 -> working=1 with no wEn.
- Wrap: with BASE_ADDR=510, load 3 words -> addresses 510, 511, 0.
- Data that looks like commands: load a word of A5 5A A5 5A -> wDat=a55aa55a written; state machine unaffected.
- Reset mid-load: drop rst_n after 2 bytes of word 1 (word 0 already written) -> all outputs 0 immediately. Re-run the full load from the first scenario and it completes normally.
